// File: rtl/serial_receiver.sv
// serial_receiver: receives 8N1-style asynchronous frames on the serial line
// and presents each good payload byte as a parallel word.
// The FSM is paced by an external sample strobe that arrives OVERSAMPLE
// times per bit period.
// Optional build macro SERIAL_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit. It also drives o_parity_error.
// Without the macro, o_parity_error is tied low.
module serial_receiver #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sample_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_valid,
    output logic                 o_frame_error,
    output logic                 o_busy,
    output logic                 o_parity_error
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    // Tick count at the middle of the start bit, counted from the falling edge.
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    // Tick count one full bit period after the previous mid-bit sample.
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                r_state;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shreg;
    logic                  w_mid_bit;

`ifdef SERIAL_RX_PARITY_EN
    logic                  r_par_bad;
    logic                  r_parity_error;
`endif

    // Two-flop synchroniser for the asynchronous line.
    // It presets to the idle level so that reset does not look like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Mid-bit point of a data, parity or stop bit, one bit period after the previous sample.
    always_comb begin
        w_mid_bit = i_sample_tick && (r_tick_cnt == LAST_TICK);
    end

    // Receive FSM with registered outputs.
    // The pulse outputs default low every clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_shreg        <= '0;
            o_data         <= '0;
            o_data_valid   <= 1'b0;
            o_frame_error  <= 1'b0;
            o_busy         <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par_bad      <= 1'b0;
            r_parity_error <= 1'b0;
`endif
        end else begin
            o_data_valid   <= 1'b0;
            o_frame_error  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_parity_error <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                        o_busy     <= 1'b1;
                    end
                end

                S_START: begin
                    if (i_sample_tick) begin
                        if (r_tick_cnt == MID_TICK) begin
                            r_tick_cnt <= '0;
                            if (r_rx_s) begin
                                // Line went back high before mid start bit: glitch.
                                r_state <= S_IDLE;
                                o_busy  <= 1'b0;
                            end else begin
                                r_state   <= S_DATA;
                                r_bit_cnt <= '0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (w_mid_bit) begin
                        r_tick_cnt <= '0;
                        // The line carries the LSB first.
                        // Shifting in at the MSB leaves bit 0 in place after the last bit.
                        r_shreg    <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            r_state   <= S_PARITY;
`else
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (i_sample_tick) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end

`ifdef SERIAL_RX_PARITY_EN
                S_PARITY: begin
                    if (w_mid_bit) begin
                        r_tick_cnt <= '0;
                        // Even parity: the parity bit plus the data bits hold an even number of ones.
                        r_par_bad  <= r_rx_s ^ (^r_shreg);
                        r_state    <= S_STOP;
                    end else if (i_sample_tick) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (w_mid_bit) begin
                        r_tick_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            o_busy  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
                            if (r_par_bad) begin
                                r_parity_error <= 1'b1;
                            end else begin
                                o_data       <= r_shreg;
                                o_data_valid <= 1'b1;
                            end
`else
                            o_data       <= r_shreg;
                            o_data_valid <= 1'b1;
`endif
                        end else begin
                            // Bad stop bit: keep the last good byte.
                            // Wait for the line to return high.
                            o_frame_error  <= 1'b1;
                            r_state        <= S_BREAK;
`ifdef SERIAL_RX_PARITY_EN
                            r_parity_error <= r_par_bad;
`endif
                        end
                    end else if (i_sample_tick) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end

                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    assign o_parity_error = r_parity_error;
`else
    assign o_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard testbench for serial_receiver.
// The stimulus process pushes expected output events into a queue before sending each frame.
// A monitor process pops and checks an entry on every data_valid, frame_error or parity_error pulse.
// Timing: sample_tick every 4 clocks, so one bit period is 64 clocks.
module tb_serial_receiver;

    localparam int unsigned BIT_CLKS = 64;

    localparam int EV_VALID  = 0;
    localparam int EV_FRAME  = 1;
    localparam int EV_PARITY = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;
    logic       parity_error;

    ev_t        exp_q[$];
    int         n_cmp;
    int         n_err;
    logic [7:0] last_good;

    serial_receiver #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sample_tick  (tick),
        .i_rx           (rx),
        .o_data         (data),
        .o_data_valid   (data_valid),
        .o_frame_error  (frame_error),
        .o_busy         (busy),
        .o_parity_error (parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clock sample strobe every fourth clock, driven away from the active edge.
    initial begin
        int unsigned cnt;
        cnt  = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = (cnt == 3);
            cnt  = (cnt + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input logic par_en, input logic par_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (par_en) send_bit(par_v);
        send_bit(stop_v);
    endtask

    // Monitor: every pulse must match the next expected event.
    initial begin
        ev_t e;
        int  obs;
        forever begin
            @(negedge clk);
            if (data_valid && frame_error) begin
                n_cmp++;
                n_err++;
                $display("FAIL pulse_exclusive: data_valid and frame_error both high");
            end
            if (data_valid || frame_error || parity_error) begin
                obs = data_valid ? EV_VALID : (frame_error ? EV_FRAME : EV_PARITY);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got kind %0d data %0h expected none", obs, data);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(obs), 32'(e.kind));
                    check("event_data", {24'h0, data}, {24'h0, e.data});
                end
            end
        end
    end

    // Stimulus.
    initial begin
        n_cmp     = 0;
        n_err     = 0;
        last_good = 8'h00;
        rst_n     = 1'b0;
        rx        = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",   {24'h0, data}, 32'h0);
        check("rst_valid",  32'(data_valid), 32'h0);
        check("rst_ferr",   32'(frame_error), 32'h0);
        check("rst_busy",   32'(busy), 32'h0);
        check("rst_perr",   32'(parity_error), 32'h0);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);

        // 1. Good frame 0xA5.
        push(EV_VALID, 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        last_good = 8'hA5;
        repeat (8) @(negedge clk);
        check("t1_busy_idle", 32'(busy), 32'h0);
        check("t1_data_held", {24'h0, data}, 32'hA5);
        repeat (BIT_CLKS) @(negedge clk);

        // 2. Start glitch of three ticks.
        rx = 1'b0;
        repeat (12) @(negedge clk);
        check("t2_busy_start", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("t2_busy_abort", 32'(busy), 32'h0);

        // 3. 0x3C with a low stop bit, line then held low for a further bit time.
        push(EV_FRAME, last_good);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        check("t3_busy_break", 32'(busy), 32'h1);
        check("t3_data_kept", {24'h0, data}, 32'hA5);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("t3_busy_release", 32'(busy), 32'h0);
        repeat (BIT_CLKS) @(negedge clk);

        // 4. Back-to-back frames.
        push(EV_VALID, 8'h55);
        push(EV_VALID, 8'hFF);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        last_good = 8'hFF;
        repeat (BIT_CLKS) @(negedge clk);
        check("t4_data_last", {24'h0, data}, 32'hFF);

        // 5. Reset asserted in the middle of bit 4 of 0x81.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("t5_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("t5_rst_data", {24'h0, data}, 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_valid", 32'(data_valid), 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("t5_idle_busy", 32'(busy), 32'h0);
        push(EV_VALID, 8'h81);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        check("t5_data_after", {24'h0, data}, 32'h81);

`ifdef SERIAL_RX_PARITY_EN
        // 6. Parity: 0x07 holds three ones, so the even-parity bit is 1.
        push(EV_VALID, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        push(EV_PARITY, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        check("t6_data_kept", {24'h0, data}, 32'h07);
`endif

        repeat (2 * BIT_CLKS) @(negedge clk);
        check("events_outstanding", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
